// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory channel arbiter: FSM states, grant owner and the
// downstream command payload.
package memory_arbiter_pkg;

    // Command register is sized for the widest supported channel configuration.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        LOAD,
        STORE
    } grant_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_DATA_W-1:0] data;
        logic                  write;
    } mem_command_t;

endpackage

// File: rtl/channel_request_latch.sv
// One-entry pending request holder for a single CPU-side channel; reports a
// request that arrives while the entry stays occupied.
module channel_request_latch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  request_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  clear_i,
    input  logic                  issue_i,
    output logic                  pending_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  overrun_c
);

    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  kept_c;

    // Entry survives the cycle unless it is handed to the FSM or cancelled.
    always_comb begin
        kept_c    = pending_q & ~issue_i & ~clear_i;
        pending_d = kept_c | request_i;
        address_d = address_q;
        data_d    = data_q;
        overrun_c = request_i & kept_c;
        if (request_i && !kept_c) begin
            address_d = address_i;
            data_d    = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            address_q <= address_d;
            data_q    <= data_d;
        end
    end

    assign pending_o = pending_q;
    assign address_o = address_q;
    assign data_o    = data_q;

endmodule

// File: rtl/memory_channel_arbiter.sv
// Round-robin arbiter sharing one memory command port between load and store
// channels. Define ARBITER_WATCHDOG_EN to abort stalled transactions.
module memory_channel_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_request_i,
    input  logic [ADDR_WIDTH-1:0] load_address_i,
    input  logic                  load_invalidate_i,
    output logic                  load_valid_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    input  logic                  store_request_i,
    input  logic [ADDR_WIDTH-1:0] store_address_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  store_done_o,
    output logic                  mem_request_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_done_i,
    output logic                  overrun_o,
    output logic                  error_o
);

    logic                  load_pending, store_pending;
    logic [ADDR_WIDTH-1:0] load_address, store_address;
    logic [DATA_WIDTH-1:0] store_data, unused_load_data;
    logic                  load_overrun_c, store_overrun_c;
    logic                  load_issue_c, store_issue_c, load_clear_c;
    logic                  load_ready_c, inflight_load_c;

    arb_state_t            state_q, state_d;
    grant_t                last_grant_q, last_grant_d;
    logic                  drop_q, drop_d;
    mem_command_t          cmd_q, cmd_d;
    logic                  mem_request_q, mem_request_d;
    logic                  load_valid_q, load_valid_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  store_done_q, store_done_d;
    logic                  overrun_q, overrun_d;

    channel_request_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_load_latch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (load_request_i),
        .address_i (load_address_i),
        .data_i    ('0),
        .clear_i   (load_clear_c),
        .issue_i   (load_issue_c),
        .pending_o (load_pending),
        .address_o (load_address),
        .data_o    (unused_load_data),
        .overrun_c (load_overrun_c)
    );

    channel_request_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_store_latch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (store_request_i),
        .address_i (store_address_i),
        .data_i    (store_data_i),
        .clear_i   (1'b0),
        .issue_i   (store_issue_c),
        .pending_o (store_pending),
        .address_o (store_address),
        .data_o    (store_data),
        .overrun_c (store_overrun_c)
    );

`ifdef ARBITER_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        drop_d        = drop_q;
        cmd_d         = cmd_q;
        mem_request_d = 1'b0;
        load_valid_d  = 1'b0;
        load_data_d   = load_data_q;
        store_done_d  = 1'b0;
        overrun_d     = load_overrun_c | store_overrun_c;
        load_issue_c  = 1'b0;
        store_issue_c = 1'b0;
        load_clear_c  = 1'b0;
`ifdef ARBITER_WATCHDOG_EN
        wd_d          = wd_q;
        error_d       = 1'b0;
`endif

        // Invalidate hits the in-flight load first, else the latched one.
        inflight_load_c = (state_q != IDLE) && (last_grant_q == LOAD);
        if (load_invalidate_i) begin
            if (inflight_load_c && !drop_q) begin
                drop_d = 1'b1;
            end else if (load_pending) begin
                load_clear_c = 1'b1;
            end
        end
        load_ready_c = load_pending & ~load_clear_c;

        case (state_q)
            IDLE: begin
                if (load_ready_c && (!store_pending || last_grant_q == STORE)) begin
                    load_issue_c  = 1'b1;
                    last_grant_d  = LOAD;
                    cmd_d         = '{address: CMD_ADDR_W'(load_address), data: '0, write: 1'b0};
                    mem_request_d = 1'b1;
                    state_d       = ISSUE;
                end else if (store_pending) begin
                    store_issue_c = 1'b1;
                    last_grant_d  = STORE;
                    cmd_d         = '{address: CMD_ADDR_W'(store_address),
                                      data: CMD_DATA_W'(store_data), write: 1'b1};
                    mem_request_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ARBITER_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            WAIT: begin
                if (last_grant_q == LOAD && mem_valid_i) begin
                    load_valid_d = ~drop_d;
                    load_data_d  = mem_data_i;
                    drop_d       = 1'b0;
                    state_d      = IDLE;
                end else if (last_grant_q == STORE && mem_done_i) begin
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end
`ifdef ARBITER_WATCHDOG_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                    if (last_grant_q == LOAD) begin
                        load_valid_d = ~drop_d;
                        load_data_d  = '0;
                    end else begin
                        store_done_d = 1'b1;
                    end
                    drop_d = 1'b0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= STORE;
            drop_q        <= 1'b0;
            cmd_q         <= '0;
            mem_request_q <= 1'b0;
            load_valid_q  <= 1'b0;
            load_data_q   <= '0;
            store_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            drop_q        <= drop_d;
            cmd_q         <= cmd_d;
            mem_request_q <= mem_request_d;
            load_valid_q  <= load_valid_d;
            load_data_q   <= load_data_d;
            store_done_q  <= store_done_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign mem_request_o = mem_request_q;
    assign mem_write_o   = cmd_q.write;
    assign mem_address_o = ADDR_WIDTH'(cmd_q.address);
    assign mem_data_o    = DATA_WIDTH'(cmd_q.data);
    assign load_valid_o  = load_valid_q;
    assign load_data_o   = load_data_q;
    assign store_done_o  = store_done_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_memory_channel_arbiter.sv
// Bench for memory_channel_arbiter: vector table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_memory_channel_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        load_request_i, load_invalidate_i, store_request_i;
    logic [31:0] load_address_i, store_address_i, store_data_i;
    logic        load_valid_o, store_done_o, mem_request_o, mem_write_o;
    logic [31:0] load_data_o, mem_address_o, mem_data_o, mem_data_i;
    logic        mem_valid_i, mem_done_i, overrun_o, error_o;

    always #5 clk_i = ~clk_i;

    memory_channel_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .load_request_i(load_request_i), .load_address_i(load_address_i),
        .load_invalidate_i(load_invalidate_i), .load_valid_o(load_valid_o),
        .load_data_o(load_data_o), .store_request_i(store_request_i),
        .store_address_i(store_address_i), .store_data_i(store_data_i),
        .store_done_o(store_done_o), .mem_request_o(mem_request_o),
        .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
        .mem_data_o(mem_data_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .mem_done_i(mem_done_i), .overrun_o(overrun_o), .error_o(error_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int c_req, c_sdone, c_lvalid, c_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        load_request_i = 0; load_invalidate_i = 0; store_request_i = 0;
        mem_valid_i = 0; mem_done_i = 0;
        load_address_i = '0; store_address_i = '0; store_data_i = '0; mem_data_i = '0;
    endtask

    // One clock: inputs set beforehand are sampled, outputs observed #1 later.
    task automatic tick();
        @(posedge clk_i);
        #1;
        c_req    += int'(mem_request_o);
        c_sdone  += int'(store_done_o);
        c_lvalid += int'(load_valid_o);
        c_ovr    += int'(overrun_o);
        clear_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"}, mem_request_o, 0);
        check({tag, " write"}, mem_write_o, 0);
        check({tag, " addr"}, mem_address_o, 0);
        check({tag, " wdata"}, mem_data_o, 0);
        check({tag, " lvalid"}, load_valid_o, 0);
        check({tag, " ldata"}, load_data_o, 0);
        check({tag, " sdone"}, store_done_o, 0);
        check({tag, " ovr"}, overrun_o, 0);
        check({tag, " err"}, error_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
    endtask

    typedef struct {
        logic        lreq;  logic [31:0] laddr;
        logic        sreq;  logic [31:0] saddr; logic [31:0] sdata;
        logic        mv;    logic        md;    logic [31:0] mdata;
        logic        e_req; logic        e_wr;  logic [31:0] e_addr; logic [31:0] e_wdata;
        logic        e_lv;  logic [31:0] e_ld;  logic        e_sd;
    } vec_t;

    // Reference model: pending slots, one outstanding transaction, round-robin.
    bit          m_pend [2];
    logic [31:0] m_paddr[2];
    logic [31:0] m_pdata;
    bit          m_busy, m_issued, m_op, m_drop, m_last;
    int          m_wait;
    logic        e_req, e_wr, e_lv, e_sd, e_ov;
    logic [31:0] e_addr, e_wdata, e_ld;

    task automatic model_reset();
        m_pend = '{0, 0}; m_busy = 0; m_issued = 0; m_op = 0; m_drop = 0;
        m_last = 1; m_wait = 0;
    endtask

    task automatic model_step(input bit lreq, input logic [31:0] laddr, input bit sreq,
                              input logic [31:0] saddr, input logic [31:0] sdata,
                              input bit inv, input bit mv, input bit md,
                              input logic [31:0] mdata);
        bit was_busy = m_busy;
        bit was_issued = m_issued;
        bit cancel_l = 0, take_l = 0, take_s = 0, lr, kept_l, kept_s;
        e_req = 0; e_lv = 0; e_sd = 0; e_ov = 0;
        if (inv) begin
            if (was_busy && m_op == 0 && !m_drop) m_drop = 1;
            else if (m_pend[0]) cancel_l = 1;
        end
        if (was_busy && was_issued) begin
            m_wait++;
            if (m_op == 0 && mv) begin
                e_lv = !m_drop; e_ld = mdata; m_busy = 0; m_drop = 0;
            end else if (m_op == 1 && md) begin
                e_sd = 1; m_busy = 0;
            end
        end else if (was_busy) begin
            m_issued = 1; m_wait = 0;
        end else begin
            lr = m_pend[0] && !cancel_l;
            if (lr || m_pend[1]) begin
                m_op = (lr && (!m_pend[1] || m_last)) ? 1'b0 : 1'b1;
                take_l = !m_op; take_s = m_op;
                m_last = m_op; m_busy = 1; m_issued = 0;
                e_req = 1; e_wr = m_op; e_addr = m_paddr[m_op];
                e_wdata = m_op ? m_pdata : 32'h0;
            end
        end
        kept_l = m_pend[0] && !cancel_l && !take_l;
        kept_s = m_pend[1] && !take_s;
        m_pend[0] = kept_l; m_pend[1] = kept_s;
        if (lreq) begin
            if (kept_l) e_ov = 1;
            else begin m_pend[0] = 1; m_paddr[0] = laddr; end
        end
        if (sreq) begin
            if (kept_s) e_ov = 1;
            else begin m_pend[1] = 1; m_paddr[1] = saddr; m_pdata = sdata; end
        end
    endtask

    initial begin
        vec_t vt[24];
        bit r_l, r_s, r_i, r_v, r_d;
        logic [31:0] r_la, r_sa, r_sd, r_md;
        // Fields: lreq,laddr, sreq,saddr,sdata, mv,md,mdata, e_req,e_wr,e_addr,e_wdata, e_lv,e_ld, e_sd
        vt[0]  = '{1, 32'h100, 1, 32'h200, 32'h11112222, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 1, 0, 32'h0A0A0A0A, 0, 0, 0, 0, 1, 32'h0A0A0A0A, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 32'h11112222, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80000010, 0, 0, 0, 0};
        vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0};
        vt[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[16] = '{1, 32'h300, 1, 32'h400, 32'h33334444, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h400, 32'h33334444, 0, 0, 0};
        vt[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0, 0};
        vt[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[22] = '{0, 0, 0, 0, 0, 1, 0, 32'h55667788, 0, 0, 0, 0, 1, 32'h55667788, 0};
        vt[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        clear_inputs();
        c_req = 0; c_sdone = 0; c_lvalid = 0; c_ovr = 0;
        do_reset();
        check_all_zero("reset");

        for (int i = 0; i < 24; i++) begin
            load_request_i = vt[i].lreq;  load_address_i = vt[i].laddr;
            store_request_i = vt[i].sreq; store_address_i = vt[i].saddr;
            store_data_i = vt[i].sdata;   mem_valid_i = vt[i].mv;
            mem_done_i = vt[i].md;        mem_data_i = vt[i].mdata;
            tick();
            check($sformatf("vec%0d req", i), mem_request_o, vt[i].e_req);
            if (vt[i].e_req) begin
                check($sformatf("vec%0d write", i), mem_write_o, vt[i].e_wr);
                check($sformatf("vec%0d addr", i), mem_address_o, vt[i].e_addr);
                check($sformatf("vec%0d wdata", i), mem_data_o, vt[i].e_wdata);
            end
            check($sformatf("vec%0d lvalid", i), load_valid_o, vt[i].e_lv);
            if (vt[i].e_lv) check($sformatf("vec%0d ldata", i), load_data_o, vt[i].e_ld);
            check($sformatf("vec%0d sdone", i), store_done_o, vt[i].e_sd);
            check($sformatf("vec%0d ovr", i), overrun_o, 0);
        end

        // Invalidate a latched load while a store occupies the port.
        store_request_i = 1; store_address_i = 32'h500; store_data_i = 32'h5555AAAA;
        tick(); tick();
        check("inv_pre store issued", mem_request_o, 1);
        load_request_i = 1; load_address_i = 32'h600;
        tick();
        load_invalidate_i = 1;
        tick();
        mem_done_i = 1;
        tick();
        check("inv_pre sdone", store_done_o, 1);
        c_req = 0;
        repeat (4) tick();
        check("inv_pre no load cmd", c_req, 0);

        // Invalidate while the load waits for memory.
        c_lvalid = 0;
        load_request_i = 1; load_address_i = 32'h700;
        tick(); tick();
        check("inv_wait issued addr", mem_address_o, 32'h700);
        tick();
        load_invalidate_i = 1;
        tick();
        mem_valid_i = 1; mem_data_i = 32'h12345678;
        tick();
        check("inv_wait lvalid", load_valid_o, 0);
        tick();
        check("inv_wait lvalid total", c_lvalid, 0);

        // Overrun on the store latch.
        c_req = 0; c_sdone = 0; c_ovr = 0;
        store_request_i = 1; store_address_i = 32'hA00; store_data_i = 32'h1;
        tick(); tick();
        store_request_i = 1; store_address_i = 32'hA04; store_data_i = 32'h2;
        tick();
        store_request_i = 1; store_address_i = 32'hA08; store_data_i = 32'h3;
        tick();
        check("ovr pulse", overrun_o, 1);
        tick();
        check("ovr one cycle", overrun_o, 0);
        mem_done_i = 1;
        tick(); tick();
        check("ovr second addr", mem_address_o, 32'hA04);
        tick();
        mem_done_i = 1;
        tick(); tick();
        check("ovr sdone total", c_sdone, 2);
        check("ovr cmd total", c_req, 2);
        check("ovr pulse total", c_ovr, 1);

        // Reset in WAIT, then a late response.
        load_request_i = 1; load_address_i = 32'hB00;
        tick(); tick(); tick();
        rst_i = 1;
        tick();
        rst_i = 0;
        check_all_zero("rst_wait");
        mem_valid_i = 1; mem_data_i = 32'hFFFF0000;
        tick();
        check("rst_late lvalid", load_valid_o, 0);
        tick();
        load_request_i = 1; load_address_i = 32'hB40;
        tick(); tick();
        check("rst_after req", mem_request_o, 1);
        check("rst_after addr", mem_address_o, 32'hB40);
        tick();
        mem_valid_i = 1; mem_data_i = 32'hCAFEF00D;
        tick();
        check("rst_after lvalid", load_valid_o, 1);
        check("rst_after ldata", load_data_o, 32'hCAFEF00D);

        // Memory never answers a store.
        store_request_i = 1; store_address_i = 32'hC00; store_data_i = 32'h77;
        tick(); tick();
        check("wd store issued", mem_request_o, 1);
        c_sdone = 0; c_req = 0;
`ifdef ARBITER_WATCHDOG_EN
        repeat (16) tick();
        check("wd early sdone", c_sdone, 0);
        tick();
        check("wd sdone", store_done_o, 1);
        check("wd error", error_o, 1);
`else
        repeat (40) tick();
        check("wd hold sdone", c_sdone, 0);
        check("wd hold req", c_req, 0);
        check("wd error tied", error_o, 0);
`endif
        do_reset();

        // Randomized run against the reference model.
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_l = ($urandom_range(0, 2) == 0); r_la = $urandom;
            r_s = ($urandom_range(0, 2) == 0); r_sa = $urandom; r_sd = $urandom;
            r_i = ($urandom_range(0, 7) == 0);
            r_v = ($urandom_range(0, 3) == 0); r_d = ($urandom_range(0, 3) == 0);
            r_md = $urandom;
            if (m_busy && m_issued && m_wait >= 8) begin
                if (m_op) r_d = 1; else r_v = 1;
            end
            load_request_i = r_l; load_address_i = r_la; load_invalidate_i = r_i;
            store_request_i = r_s; store_address_i = r_sa; store_data_i = r_sd;
            mem_valid_i = r_v; mem_done_i = r_d; mem_data_i = r_md;
            model_step(r_l, r_la, r_s, r_sa, r_sd, r_i, r_v, r_d, r_md);
            tick();
            check($sformatf("rnd%0d req", cyc), mem_request_o, e_req);
            if (e_req) begin
                check($sformatf("rnd%0d write", cyc), mem_write_o, e_wr);
                check($sformatf("rnd%0d addr", cyc), mem_address_o, e_addr);
                check($sformatf("rnd%0d wdata", cyc), mem_data_o, e_wdata);
            end
            check($sformatf("rnd%0d lvalid", cyc), load_valid_o, e_lv);
            if (e_lv) check($sformatf("rnd%0d ldata", cyc), load_data_o, e_ld);
            check($sformatf("rnd%0d sdone", cyc), store_done_o, e_sd);
            check($sformatf("rnd%0d ovr", cyc), overrun_o, e_ov);
            check($sformatf("rnd%0d err", cyc), error_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
